udp_tx_hdr_insert: RTL
======================

# udp_tx_hdr_insert

UDP transmit framer that sits directly downstream of `udp_shift_register`, which is configured as an 8-deep fixed-latency delay line. While the payload bytes travel through that delay line, this block emits the 8-byte UDP header: source port, destination port, length, and checksum. It then forwards the delayed payload, so the header and payload leave as one contiguous byte stream towards the IP/MAC stage. Checksum is transmitted as 0x0000 (IPv4 "no checksum").

## Interface
- `HDR_LEN`, 8, header bytes; must equal the upstream `udp_shift_register` FIXED_DEPTH.
- `DATA_WIDTH`, 8, byte width; only 8 is supported.
- `SRC_PORT`, 16'h1F90, constant source port.
- `clk_tb`  in  1  clock.
- `tb_rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  payload byte valid; same cycle as the byte entering `udp_shift_register` din.
- `in_sof`  in  1  first payload byte; qualified by `in_valid`.
- `in_last`  in  1  last payload byte; qualified by `in_valid`.
- `in_len`  in  16  payload byte count; sampled with `in_sof`.
- `dst_port`  in  16  destination port; sampled with `in_sof`.
- `dly_data`  in  8  `udp_shift_register` dout (din delayed by 8 clocks).
- `out_valid`  out  1  output byte valid.
- `out_sof`  out  1  first header byte.
- `out_last`  out  1  last payload byte.
- `out_data`  out  8  header or payload byte.
- `busy`  out  1  state is not IDLE.
- `len_err`  out  1  sticky: the actual payload count did not match `in_len`.
- `ovl_err`  out  1  sticky: `in_sof` arrived while the block was not IDLE.

## Operation
- Header byte order: SRC_PORT[15:8], SRC_PORT[7:0], dst[15:8], dst[7:0], ulen[15:8], ulen[7:0], 0x00, 0x00.
- `ulen` = `in_len` + 8, computed modulo 2^16; overflow wraps silently.
- FSM states:
  - IDLE: on `in_valid & in_sof`, latch `dst_port` and `ulen`, clear the header counter, go to HDR.
  - HDR: emit header byte [hcnt] each cycle; after byte 7 go to PAY.
  - PAY: `out_valid`, `out_data`, `out_last` come from the 9-deep control delay line (valid/last) and `dly_data`. On the cycle that emits the delayed last byte, go to IDLE.
- The control delay line is 9 stages of {valid, last}. It is loaded only with beats of the accepted packet; beats of rejected packets are masked to 0.
- Payload counter: 16 bits, counts accepted input beats. At `in_last`, if count ≠ latched `in_len`, set `len_err`.
- Overlap: `in_sof` seen outside IDLE sets `ovl_err`. That packet's beats are masked up to and including its `in_last`. The current packet is unaffected.
- `in_sof & in_last` in the same beat is a 1-byte payload and is legal.
- Gaps (`in_valid`=0) inside a packet are legal; they appear as gaps in the PAY output.
- `in_valid` without a preceding `in_sof` while IDLE is ignored.
- Reset mid-packet: every state, the delay line, the counters and both error flags clear immediately. The partial frame is lost, with no trailing `out_last`.
- Reset values: `out_valid`=0, `out_sof`=0, `out_last`=0, `out_data`=0x00, `busy`=0, `len_err`=0, `ovl_err`=0.

## Timing
- `in_sof` is sampled at edge n0. Header byte k is valid after edge n0+1+k, for k = 0..7.
- Payload byte j, input at edge n0+j, appears after edge n0+9+j. Latency is 9 clocks for every payload byte.
- Output is contiguous: the last header byte is followed immediately by payload byte 0 when the input had no gaps.
- A new packet is accepted only if its `in_sof` edge is at least last_in+9, i.e. at least 8 idle cycles after the previous `in_last`. Anything earlier triggers the overlap rule.
- All outputs are registered; there is no combinational input-to-output path.
- No backpressure: downstream must accept every `out_valid` beat.

## Structure
- Shared package `udp_pkg`: UDP_HDR_LEN = 8, DEFAULT_SRC_PORT, FSM state encoding (IDLE/HDR/PAY), and a header-byte-select function.
- Sub-module `udp_ctrl_delay`: a parameterised N-stage {valid, last} shift register with async reset; instantiated with N = 9.
- The top level holds the FSM, latches, counters, header mux and error flags.
- The bench instantiates `udp_shift_register` and this block back-to-back.

## Test plan
- 4-byte payload 0xA1..0xA4, `in_len`=4, `dst_port`=0x1234, sof at edge 10 → bytes 1F 90 12 34 00 0C 00 00 A1 A2 A3 A4 after edges 11..22. `out_sof` after edge 11, `out_last` after edge 22, `len_err`=0.
- 1-byte payload 0x55 with `in_sof`=`in_last`, `in_len`=1 → 9-byte frame with ulen 0x0009; `out_sof` and `out_last` 8 cycles apart.
- Payload of 3 bytes with one idle cycle between bytes 1 and 2 → identical header; payload bytes after edges n0+9, n0+10, n0+12; `out_valid`=0 after edge n0+11.
- `in_len`=5 but `in_last` on the 3rd byte → `len_err`=1 from the cycle after `in_last`; the frame still completes.
- Second `in_sof` 4 cycles after the previous `in_last` → `ovl_err`=1, no second frame emitted; a third packet with a gap ≥ 8 cycles is framed correctly.
- Assert `tb_rst` during PAY → all outputs 0 and `busy`=0 immediately; the next packet after release is framed correctly.

Source files
------------

// File: rtl/udp_pkg.sv
// Shared definitions for the UDP transmit path: header geometry, default
// source port, framer state encoding and the header byte selector.
package udp_pkg;

    localparam int          UDP_HDR_LEN      = 8;
    localparam logic [15:0] DEFAULT_SRC_PORT = 16'h1F90;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_PAY  = 2'd2
    } udp_state_e;

    // Wire order: src port, dst port, length, checksum (always zero on IPv4).
    function automatic logic [7:0] udp_hdr_byte(
        input logic [2:0]  idx,
        input logic [15:0] src,
        input logic [15:0] dst,
        input logic [15:0] ulen
    );
        logic [7:0] b;
        case (idx)
            3'd0:    b = src[15:8];
            3'd1:    b = src[7:0];
            3'd2:    b = dst[15:8];
            3'd3:    b = dst[7:0];
            3'd4:    b = ulen[15:8];
            3'd5:    b = ulen[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/udp_tx_hdr_insert_if.sv
// Byte-stream bundle between the payload source, the upstream delay line
// and the UDP header framer.
interface udp_tx_hdr_insert_if;

    logic        in_valid;
    logic        in_sof;
    logic        in_last;
    logic [15:0] in_len;
    logic [15:0] dst_port;
    logic [7:0]  dly_data;
    logic        out_valid;
    logic        out_sof;
    logic        out_last;
    logic [7:0]  out_data;
    logic        busy;
    logic        len_err;
    logic        ovl_err;

    modport slave (
        input  in_valid, in_sof, in_last, in_len, dst_port, dly_data,
        output out_valid, out_sof, out_last, out_data, busy, len_err, ovl_err
    );

    modport master (
        output in_valid, in_sof, in_last, in_len, dst_port, dly_data,
        input  out_valid, out_sof, out_last, out_data, busy, len_err, ovl_err
    );

endinterface

// File: rtl/udp_ctrl_delay.sv
// N-stage {valid, last} delay line that keeps payload framing aligned with
// the data delay line.
module udp_ctrl_delay #(
    parameter int N = 9
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_valid,
    input  logic i_last,
    output logic o_valid,
    output logic o_last
);

    logic [N-1:0] r_valid;
    logic [N-1:0] r_last;

    // Advance both control bits one stage per clock
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= {N{1'b0}};
            r_last  <= {N{1'b0}};
        end else begin
            r_valid <= {r_valid[N-2:0], i_valid};
            r_last  <= {r_last[N-2:0], i_last};
        end
    end

    assign o_valid = r_valid[N-1];
    assign o_last  = r_last[N-1];

endmodule

// File: rtl/udp_shift_register.sv
// Fixed-latency payload delay line feeding the header framer: din is captured
// and then held back FIXED_DEPTH further clocks so it meets the framer's PAY tap.
module udp_shift_register #(
    parameter int FIXED_DEPTH = 8,
    parameter int DATA_WIDTH  = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [DATA_WIDTH-1:0] i_din,
    output logic [DATA_WIDTH-1:0] o_dout
);

    logic [DATA_WIDTH-1:0] r_in;
    logic [DATA_WIDTH-1:0] r_sr [FIXED_DEPTH];

    // Capture stage followed by the fixed-depth shift chain
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_in <= {DATA_WIDTH{1'b0}};
            for (int i = 0; i < FIXED_DEPTH; i++) begin
                r_sr[i] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            r_in    <= i_din;
            r_sr[0] <= r_in;
            for (int i = 1; i < FIXED_DEPTH; i++) begin
                r_sr[i] <= r_sr[i-1];
            end
        end
    end

    assign o_dout = r_sr[FIXED_DEPTH-1];

endmodule

// File: rtl/udp_tx_hdr_insert.sv
// UDP transmit framer: emits the 8-byte header while the payload sits in the
// upstream delay line, then forwards the delayed payload back-to-back.
module udp_tx_hdr_insert
    import udp_pkg::*;
#(
    parameter int          HDR_LEN    = UDP_HDR_LEN,
    parameter int          DATA_WIDTH = 8,
    parameter logic [15:0] SRC_PORT   = DEFAULT_SRC_PORT
) (
    input logic                  clk_tb,
    input logic                  tb_rst,
    udp_tx_hdr_insert_if.slave   u_bus
);

    localparam logic [2:0]  HCNT_LAST = 3'(HDR_LEN - 1);
    localparam logic [15:0] HDR_LEN16 = 16'(HDR_LEN);

    udp_state_e            r_state;
    logic [2:0]            r_hcnt;
    logic [15:0]           r_dst;
    logic [15:0]           r_ulen;
    logic [15:0]           r_len;
    logic [15:0]           r_pcnt;
    logic                  r_in_pkt;
    logic                  r_drop;
    logic                  r_len_err;
    logic                  r_ovl_err;
    logic                  r_busy;
    logic                  r_out_valid;
    logic                  r_out_sof;
    logic                  r_out_last;
    logic [DATA_WIDTH-1:0] r_out_data;

    logic        w_dly_valid;
    logic        w_dly_last;
    logic        w_dly_end;
    logic        w_idle_eq;
    logic        w_start;
    logic        w_sof_bad;
    logic        w_cont;
    logic        w_beat_acc;
    logic        w_acc_last;
    logic [15:0] w_cnt_next;
    logic [15:0] w_len_ref;

    // Acceptance and beat classification; the edge that emits the delayed
    // last byte counts as idle so a new packet can start without a bubble.
    always_comb begin
        w_dly_end  = w_dly_valid & w_dly_last;
        w_idle_eq  = (r_state == ST_IDLE) | ((r_state == ST_PAY) & w_dly_end);
        w_start    = u_bus.in_valid & u_bus.in_sof & w_idle_eq;
        w_sof_bad  = u_bus.in_valid & u_bus.in_sof & ~w_idle_eq;
        w_cont     = u_bus.in_valid & ~u_bus.in_sof & r_in_pkt & ~r_drop;
        w_beat_acc = w_start | w_cont;
        w_acc_last = w_beat_acc & u_bus.in_last;
        if (w_start) begin
            w_cnt_next = 16'd1;
            w_len_ref  = u_bus.in_len;
        end else begin
            w_cnt_next = r_pcnt + 16'd1;
            w_len_ref  = r_len;
        end
    end

    udp_ctrl_delay #(
        .N (HDR_LEN + 1)
    ) u_ctrl_delay (
        .i_clk   (clk_tb),
        .i_rst   (tb_rst),
        .i_valid (w_beat_acc),
        .i_last  (w_acc_last),
        .o_valid (w_dly_valid),
        .o_last  (w_dly_last)
    );

    // Input side: header latches, payload counter, masking and sticky errors
    always_ff @(posedge clk_tb or posedge tb_rst) begin
        if (tb_rst) begin
            r_dst     <= 16'h0000;
            r_ulen    <= 16'h0000;
            r_len     <= 16'h0000;
            r_pcnt    <= 16'h0000;
            r_in_pkt  <= 1'b0;
            r_drop    <= 1'b0;
            r_len_err <= 1'b0;
            r_ovl_err <= 1'b0;
        end else begin
            if (w_start) begin
                r_dst  <= u_bus.dst_port;
                r_ulen <= u_bus.in_len + HDR_LEN16;
                r_len  <= u_bus.in_len;
            end
            if (w_beat_acc) begin
                r_pcnt   <= w_cnt_next;
                r_in_pkt <= ~u_bus.in_last;
            end
            if (w_acc_last && (w_cnt_next != w_len_ref)) begin
                r_len_err <= 1'b1;
            end
            // A rejected packet stays masked through its own last beat
            if (w_sof_bad) begin
                r_ovl_err <= 1'b1;
                r_drop    <= ~u_bus.in_last;
            end else if (u_bus.in_valid && u_bus.in_last && r_drop) begin
                r_drop <= 1'b0;
            end
        end
    end

    // Framer FSM with registered byte-stream outputs
    always_ff @(posedge clk_tb or posedge tb_rst) begin
        if (tb_rst) begin
            r_state     <= ST_IDLE;
            r_hcnt      <= 3'd0;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_sof   <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= {DATA_WIDTH{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_out_valid <= 1'b0;
                    r_out_sof   <= 1'b0;
                    r_out_last  <= 1'b0;
                    r_out_data  <= {DATA_WIDTH{1'b0}};
                    if (w_start) begin
                        r_state <= ST_HDR;
                        r_hcnt  <= 3'd0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_HDR: begin
                    r_out_valid <= 1'b1;
                    r_out_sof   <= (r_hcnt == 3'd0);
                    r_out_last  <= 1'b0;
                    r_out_data  <= udp_hdr_byte(r_hcnt, SRC_PORT, r_dst, r_ulen);
                    r_hcnt      <= r_hcnt + 3'd1;
                    if (r_hcnt == HCNT_LAST) begin
                        r_state <= ST_PAY;
                    end
                end
                ST_PAY: begin
                    r_out_valid <= w_dly_valid;
                    r_out_sof   <= 1'b0;
                    r_out_last  <= w_dly_last;
                    r_out_data  <= w_dly_valid ? u_bus.dly_data : {DATA_WIDTH{1'b0}};
                    if (w_dly_end) begin
                        if (w_start) begin
                            r_state <= ST_HDR;
                            r_hcnt  <= 3'd0;
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_busy      <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_out_sof   <= 1'b0;
                    r_out_last  <= 1'b0;
                    r_out_data  <= {DATA_WIDTH{1'b0}};
                end
            endcase
        end
    end

    assign u_bus.out_valid = r_out_valid;
    assign u_bus.out_sof   = r_out_sof;
    assign u_bus.out_last  = r_out_last;
    assign u_bus.out_data  = r_out_data;
    assign u_bus.busy      = r_busy;
    assign u_bus.len_err   = r_len_err;
    assign u_bus.ovl_err   = r_ovl_err;

endmodule
